// File: rtl/game_pkg.sv
// Shared game constants: FSM encodings, status field widths and end-page colours.
package game_pkg;

   localparam int unsigned STATE_W = 2;
   localparam int unsigned SCORE_W = 10;
   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned BCD_W   = 3 * DIGIT_W;
   localparam int unsigned TIME_W  = 8;
   localparam int unsigned LIVES_W = 2;

   localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
   localparam logic [STATE_W-1:0] ST_PLAY = 2'd1;
   localparam logic [STATE_W-1:0] ST_WON  = 2'd2;
   localparam logic [STATE_W-1:0] ST_LOST = 2'd3;

   // 12-bit RGB colours used by the end-page renderer
   localparam logic [11:0] COL_BLACK = 12'h000;
   localparam logic [11:0] COL_WHITE = 12'hFFF;
   localparam logic [11:0] COL_WIN   = 12'h0F0;
   localparam logic [11:0] COL_LOSE  = 12'hF00;

endpackage : game_pkg

// File: rtl/game_status_if.sv
// Game event pulses in, status fields out; slave side is the status block.
interface game_status_if;
   import game_pkg::*;

   logic               game_start;
   logic               score_inc;
   logic               hit;
   logic [SCORE_W-1:0] score;
   logic [BCD_W-1:0]   score_bcd;
   logic [TIME_W-1:0]  game_time;
   logic [LIVES_W-1:0] lives;
   logic               playing;
   logic               game_over;
   logic               game_won;

   modport master (
      output game_start, score_inc, hit,
      input  score, score_bcd, game_time, lives, playing, game_over, game_won
   );

   modport slave (
      input  game_start, score_inc, hit,
      output score, score_bcd, game_time, lives, playing, game_over, game_won
   );

endinterface : game_status_if

// File: rtl/bcd_digit.sv
// One BCD digit: increments on inc, wraps 9->0 with carry, synchronous clear.
module bcd_digit
   import game_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               inc,
   output logic [DIGIT_W-1:0] digit,
   output logic               carry_c
);

   // Carry ripples combinationally so all digits update on the same edge
   assign carry_c = inc && (digit == DIGIT_W'(9));

   // Digit register
   always_ff @(posedge clk) begin
      if (rst || clr)
         digit <= '0;
      else if (inc)
         digit <= carry_c ? '0 : digit + DIGIT_W'(1);
   end

endmodule : bcd_digit

// File: rtl/game_status.sv
// Game status tracker: score (binary + BCD), lives, elapsed seconds and
// IDLE/PLAY/WON/LOST state. Define GAME_TIME_LIMIT_EN to lose the game when
// game_time reaches TIME_LIMIT_S.
module game_status
   import game_pkg::*;
#(
   parameter int unsigned CLK_HZ       = 25000000,
   parameter int unsigned WIN_SCORE    = 100,
   parameter int unsigned START_LIVES  = 3,
   parameter int unsigned TIME_LIMIT_S = 120
)(
   input  logic          vga_clk,
   input  logic          sys_rst,
   game_status_if.slave  bus
);

   localparam int unsigned PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

   if (CLK_HZ < 1 || WIN_SCORE < 1 || WIN_SCORE > 999 ||
       START_LIVES < 1 || START_LIVES > 3 ||
       TIME_LIMIT_S < 1 || TIME_LIMIT_S > 255) begin : g_param_err
      $error("game_status: parameter out of range");
   end

   logic [STATE_W-1:0] state;
   logic [STATE_W-1:0] state_next;
   logic [SCORE_W-1:0] score;
   logic [TIME_W-1:0]  game_time;
   logic [LIVES_W-1:0] lives;
   logic [PRESC_W-1:0] presc;
   logic               playing;
   logic               game_over;
   logic               game_won;

   logic               in_play_c;
   logic               start_c;
   logic               tick_c;
   logic               win_c;
   logic               loss_c;
   logic               timeout_c;

   logic [DIGIT_W-1:0] dig_ones;
   logic [DIGIT_W-1:0] dig_tens;
   logic [DIGIT_W-1:0] dig_hund;
   logic               carry_ones_c;
   logic               carry_tens_c;
   logic               carry_unused;

   // Event decode for the current cycle
   always_comb begin
      in_play_c = (state == ST_PLAY);
      start_c   = bus.game_start && !in_play_c;
      tick_c    = in_play_c && (presc == PRESC_W'(CLK_HZ - 1));
      win_c     = in_play_c && bus.score_inc && (score == SCORE_W'(WIN_SCORE - 1));
      loss_c    = in_play_c && bus.hit && (lives == LIVES_W'(1));
`ifdef GAME_TIME_LIMIT_EN
      timeout_c = tick_c && (game_time == TIME_W'(TIME_LIMIT_S - 1));
`else
      timeout_c = 1'b0;
`endif
   end

   // Next-state logic; a loss beats a same-cycle win
   always_comb begin
      state_next = state;
      case (state)
         ST_PLAY: begin
            if (loss_c || timeout_c)
               state_next = ST_LOST;
            else if (win_c)
               state_next = ST_WON;
         end
         default: begin
            if (bus.game_start)
               state_next = ST_PLAY;
         end
      endcase
   end

   // State register
   always_ff @(posedge vga_clk) begin
      if (sys_rst)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   // Registered status flags mirror the upcoming state
   always_ff @(posedge vga_clk) begin
      if (sys_rst) begin
         playing   <= 1'b0;
         game_over <= 1'b0;
         game_won  <= 1'b0;
      end else begin
         playing   <= (state_next == ST_PLAY);
         game_over <= (state_next == ST_LOST);
         game_won  <= (state_next == ST_WON);
      end
   end

   // Score, lives, prescaler and seconds; frozen outside PLAY
   always_ff @(posedge vga_clk) begin
      if (sys_rst) begin
         score     <= '0;
         lives     <= '0;
         game_time <= '0;
         presc     <= '0;
      end else if (start_c) begin
         score     <= '0;
         lives     <= LIVES_W'(START_LIVES);
         game_time <= '0;
         presc     <= '0;
      end else if (in_play_c) begin
         if (bus.score_inc)
            score <= score + SCORE_W'(1);
         if (bus.hit && (lives != '0))
            lives <= lives - LIVES_W'(1);
         if (tick_c) begin
            presc <= '0;
            if (game_time != '1)
               game_time <= game_time + TIME_W'(1);
         end else begin
            presc <= presc + PRESC_W'(1);
         end
      end
   end

   bcd_digit u_ones (
      .clk     (vga_clk),
      .rst     (sys_rst),
      .clr     (start_c),
      .inc     (in_play_c && bus.score_inc),
      .digit   (dig_ones),
      .carry_c (carry_ones_c)
   );

   bcd_digit u_tens (
      .clk     (vga_clk),
      .rst     (sys_rst),
      .clr     (start_c),
      .inc     (carry_ones_c),
      .digit   (dig_tens),
      .carry_c (carry_tens_c)
   );

   bcd_digit u_hund (
      .clk     (vga_clk),
      .rst     (sys_rst),
      .clr     (start_c),
      .inc     (carry_tens_c),
      .digit   (dig_hund),
      .carry_c (carry_unused)
   );

   assign bus.score     = score;
   assign bus.score_bcd = {dig_hund, dig_tens, dig_ones};
   assign bus.game_time = game_time;
   assign bus.lives     = lives;
   assign bus.playing   = playing;
   assign bus.game_over = game_over;
   assign bus.game_won  = game_won;

endmodule : game_status

// File: tb/tb_game_status.sv
// Directed bench for game_status with CLK_HZ=10 (one game second = 10 cycles).
module tb_game_status;
   import game_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   game_status_if bus ();
   game_status_if tbus ();

   game_status #(
      .CLK_HZ(10), .WIN_SCORE(100), .START_LIVES(3), .TIME_LIMIT_S(255)
   ) dut (
      .vga_clk (clk),
      .sys_rst (rst),
      .bus     (bus.slave)
   );

   game_status #(
      .CLK_HZ(10), .WIN_SCORE(100), .START_LIVES(3), .TIME_LIMIT_S(3)
   ) dut_t (
      .vga_clk (clk),
      .sys_rst (rst),
      .bus     (tbus.slave)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      bus.game_start  = 1'b0;
      bus.score_inc   = 1'b0;
      bus.hit         = 1'b0;
      tbus.game_start = 1'b0;
      tbus.score_inc  = 1'b0;
      tbus.hit        = 1'b0;

      // Reset state
      step(2);
      check("rst_score", 32'(bus.score), 0);
      check("rst_bcd", 32'(bus.score_bcd), 0);
      check("rst_time", 32'(bus.game_time), 0);
      check("rst_lives", 32'(bus.lives), 0);
      check("rst_playing", 32'(bus.playing), 0);
      check("rst_over", 32'(bus.game_over), 0);
      check("rst_won", 32'(bus.game_won), 0);
      rst = 1'b0;

      // Start
      bus.game_start = 1'b1; step(1); bus.game_start = 1'b0;
      check("start_playing", 32'(bus.playing), 1);
      check("start_lives", 32'(bus.lives), 3);
      check("start_score", 32'(bus.score), 0);
      check("start_over", 32'(bus.game_over), 0);
      check("start_won", 32'(bus.game_won), 0);

      // BCD carries and win
      bus.score_inc = 1'b1;
      step(9);
      check("bcd_9", 32'(bus.score_bcd), 32'h009);
      step(1);
      check("bcd_10", 32'(bus.score_bcd), 32'h010);
      check("score_10", 32'(bus.score), 10);
      step(89);
      check("bcd_99", 32'(bus.score_bcd), 32'h099);
      check("play_99", 32'(bus.playing), 1);
      step(1);
      check("win_won", 32'(bus.game_won), 1);
      check("win_over", 32'(bus.game_over), 0);
      check("win_bcd", 32'(bus.score_bcd), 32'h100);
      check("win_playing", 32'(bus.playing), 0);
      step(1);
      check("won_score_hold", 32'(bus.score), 100);
      bus.score_inc = 1'b0;
      bus.hit = 1'b1; step(1); bus.hit = 1'b0;
      check("won_lives_hold", 32'(bus.lives), 3);

      // Restart from WON, then game_start in PLAY is ignored
      bus.game_start = 1'b1; step(1); bus.game_start = 1'b0;
      check("restart_score", 32'(bus.score), 0);
      check("restart_bcd", 32'(bus.score_bcd), 0);
      check("restart_won", 32'(bus.game_won), 0);
      bus.score_inc = 1'b1; step(3); bus.score_inc = 1'b0;
      check("score_3", 32'(bus.score), 3);
      bus.game_start = 1'b1; step(1); bus.game_start = 1'b0;
      check("ignore_start", 32'(bus.score), 3);
      step(16);
      check("time_2", 32'(bus.game_time), 2);

      // Three hits lose the game; values then hold
      bus.hit = 1'b1;
      step(1);
      check("lives_2", 32'(bus.lives), 2);
      step(1);
      check("lives_1", 32'(bus.lives), 1);
      check("over_pre", 32'(bus.game_over), 0);
      step(1);
      bus.hit = 1'b0;
      check("lives_0", 32'(bus.lives), 0);
      check("lost_over", 32'(bus.game_over), 1);
      check("lost_won", 32'(bus.game_won), 0);
      step(20);
      check("lost_time_hold", 32'(bus.game_time), 2);
      check("lost_score_hold", 32'(bus.score), 3);

      // Same-cycle win and loss: loss wins, score still counts
      bus.game_start = 1'b1; step(1); bus.game_start = 1'b0;
      check("restart2_lives", 32'(bus.lives), 3);
      bus.hit = 1'b1; step(2); bus.hit = 1'b0;
      check("tie_lives_1", 32'(bus.lives), 1);
      bus.score_inc = 1'b1; step(99);
      check("tie_score_99", 32'(bus.score), 99);
      bus.hit = 1'b1; step(1);
      bus.hit = 1'b0; bus.score_inc = 1'b0;
      check("tie_over", 32'(bus.game_over), 1);
      check("tie_won", 32'(bus.game_won), 0);
      check("tie_score", 32'(bus.score), 100);
      check("tie_bcd", 32'(bus.score_bcd), 32'h100);

      // Elapsed time and optional timeout
      tbus.game_start = 1'b1; step(1); tbus.game_start = 1'b0;
      check("t_playing", 32'(tbus.playing), 1);
      step(29);
      check("t_time_2", 32'(tbus.game_time), 2);
      step(1);
      check("t_time_3", 32'(tbus.game_time), 3);
`ifdef GAME_TIME_LIMIT_EN
      check("t_over", 32'(tbus.game_over), 1);
      check("t_playing_end", 32'(tbus.playing), 0);
`else
      check("t_over", 32'(tbus.game_over), 0);
      check("t_playing_end", 32'(tbus.playing), 1);
`endif

      // Reset mid-PLAY overrides score_inc; clean restart afterwards
      bus.game_start = 1'b1; step(1); bus.game_start = 1'b0;
      bus.score_inc = 1'b1; step(5);
      check("mid_score_5", 32'(bus.score), 5);
      rst = 1'b1; step(1);
      rst = 1'b0; bus.score_inc = 1'b0;
      check("mid_rst_score", 32'(bus.score), 0);
      check("mid_rst_bcd", 32'(bus.score_bcd), 0);
      check("mid_rst_time", 32'(bus.game_time), 0);
      check("mid_rst_lives", 32'(bus.lives), 0);
      check("mid_rst_playing", 32'(bus.playing), 0);
      check("mid_rst_over", 32'(bus.game_over), 0);
      check("mid_rst_won", 32'(bus.game_won), 0);
      step(3);
      check("idle_hold_score", 32'(bus.score), 0);
      bus.game_start = 1'b1; step(1); bus.game_start = 1'b0;
      check("re_playing", 32'(bus.playing), 1);
      check("re_lives", 32'(bus.lives), 3);
      check("re_score", 32'(bus.score), 0);
      bus.score_inc = 1'b1; step(1); bus.score_inc = 1'b0;
      check("re_bcd_1", 32'(bus.score_bcd), 32'h001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_game_status
